// File: rtl/ppl_pkg.sv
// ppl_pkg: shared definitions for the pixel-pipeline arbiter.
//   - FSM state encoding (IDLE / RUN / DRAIN)
//   - pixel and address widths
//   - frame size at the default resolution, plus a helper to compute it
//     for other resolutions
//   - the pixel/address pair moved by one transfer
package ppl_pkg;

   localparam int PIX_W     = 16;
   localparam int ADDR_W    = 20;
   localparam int FRAME_PIX = 1280 * 720;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } ppl_state_e;

   typedef struct packed {
      logic [PIX_W-1:0]  data;
      logic [ADDR_W-1:0] addr;
   } pix_req_t;

   function automatic int frame_pix(input int h, input int v);
      return h * v;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational N-way round-robin grant.
//   req    : request vector
//   en     : grants allowed this cycle
//   advance: the current grant is accepted; move the pointer to it
//   last_i : index granted most recently (search starts at last_i+1)
//   grant  : one-hot grant (all zero when disabled or nothing requests)
//   last_o : pointer value for the next cycle
// The pointer flop lives in the parent so it resets with the rest of the
// frame state.
module rr_arbiter
   import ppl_pkg::*;
#(
   parameter int N     = 4,
   parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req,
   input  logic             en,
   input  logic             advance,
   input  logic [IDX_W-1:0] last_i,
   output logic [N-1:0]     grant,
   output logic [IDX_W-1:0] last_o
);

   logic [IDX_W-1:0] gidx;
   logic             found;
   int               idx;

   // Scan N positions starting one past the last winner, wrapping.
   always_comb begin
      grant = '0;
      gidx  = last_i;
      found = 1'b0;
      idx   = 0;
      if (en) begin
         for (int k = 1; k <= N; k++) begin
            idx = (int'(last_i) + k) % N;
            if (!found && req[idx]) begin
               found      = 1'b1;
               grant[idx] = 1'b1;
               gidx       = IDX_W'(idx);
            end
         end
      end
   end

   // Kept separate from the scan so advance (derived from grant in the
   // parent) does not look like a loop back into the scan logic.
   assign last_o = advance ? gidx : last_i;

endmodule

// File: rtl/ppl_arbiter.sv
// ppl_arbiter: shares the pixel-alignment path among N_REQ render pipelines.
//   PPL_clk, rst_n      : clock, async active-low reset
//   req_valid/data/addr : per-requester pixel offers (packed, requester i at
//                         slice i)
//   req_ready           : one-hot grant, combinational
//   frame_start         : starts a frame when idle
//   credit_ret          : one downstream pixel consumed
//   data/data_addr/data_valid : registered granted pixel stream
//   frame_done          : pulse on the DRAIN->IDLE cycle
//   busy                : state is not IDLE
//   addr_err            : sticky, an out-of-range pixel was dropped
module ppl_arbiter
   import ppl_pkg::*;
#(
   parameter int N_REQ    = 4,
   parameter int H_DISP   = 1280,
   parameter int V_DISP   = 720,
   parameter int MAX_PEND = 64
) (
   input  logic                    PPL_clk,
   input  logic                    rst_n,
   input  logic [N_REQ-1:0]        req_valid,
   input  logic [PIX_W*N_REQ-1:0]  req_data,
   input  logic [ADDR_W*N_REQ-1:0] req_addr,
   output logic [N_REQ-1:0]        req_ready,
   input  logic                    frame_start,
   input  logic                    credit_ret,
   output logic [PIX_W-1:0]        data,
   output logic [ADDR_W-1:0]       data_addr,
   output logic                    data_valid,
   output logic                    frame_done,
   output logic                    busy,
   output logic                    addr_err
);

   localparam int FRAME_N = frame_pix(H_DISP, V_DISP);
   localparam int IDX_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int CRED_W  = $clog2(MAX_PEND) + 1;
   localparam int CNT_W   = $clog2(FRAME_N) + 1;

   localparam logic [CRED_W-1:0] CRED_MAX   = CRED_W'(MAX_PEND);
   localparam logic [CNT_W-1:0]  LAST_PIX   = CNT_W'(FRAME_N - 1);
   localparam logic [ADDR_W:0]   ADDR_LIMIT = (ADDR_W + 1)'(FRAME_N);

   ppl_state_e        state_q, state_d;
   logic [CRED_W-1:0] credits_q, credits_d;
   logic [CNT_W-1:0]  pix_cnt_q, pix_cnt_d;
   logic [IDX_W-1:0]  last_grant_q, last_grant_d;
   logic [PIX_W-1:0]  data_q, data_d;
   logic [ADDR_W-1:0] data_addr_q, data_addr_d;
   logic              data_valid_q, data_valid_d;
   logic              addr_err_q, addr_err_d;

   logic              arb_en, cnt_clr;
   logic              xfer, addr_ok, use_credit;
   logic [N_REQ-1:0]  grant;
   pix_req_t          sel_pix;

   rr_arbiter #(.N(N_REQ), .IDX_W(IDX_W)) u_rr (
      .req     (req_valid),
      .en      (arb_en),
      .advance (xfer),
      .last_i  (last_grant_q),
      .grant   (grant),
      .last_o  (last_grant_d)
   );

   assign req_ready = grant;
   assign xfer      = |grant;   // grant is only given to a valid requester

   // One-hot mux of the granted requester's pixel.
   always_comb begin
      sel_pix = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (grant[i]) begin
            sel_pix.data = req_data[PIX_W*i +: PIX_W];
            sel_pix.addr = req_addr[ADDR_W*i +: ADDR_W];
         end
      end
   end

   // Out-of-range pixels are swallowed: accepted from the requester but
   // neither forwarded, counted nor charged a credit.
   assign addr_ok    = {1'b0, sel_pix.addr} < ADDR_LIMIT;
   assign use_credit = xfer & addr_ok;

   // ---------------- FSM: state register ----------------
   always_ff @(posedge PPL_clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:  if (frame_start) state_d = ST_RUN;
         ST_RUN:   if (use_credit && pix_cnt_q == LAST_PIX) state_d = ST_DRAIN;
         ST_DRAIN: if (credits_q == CRED_MAX) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   // Credits at zero block the grant in the same cycle they run out.
   always_comb begin
      arb_en     = (state_q == ST_RUN) && (credits_q != '0);
      cnt_clr    = (state_q == ST_IDLE) && frame_start;
      frame_done = (state_q == ST_DRAIN) && (credits_q == CRED_MAX);
      busy       = (state_q != ST_IDLE);
   end

   // ---------------- datapath next values ----------------
   always_comb begin
      credits_d = credits_q;
      unique case ({use_credit, credit_ret})
         2'b10:   credits_d = credits_q - 1'b1;
         2'b01:   if (credits_q != CRED_MAX) credits_d = credits_q + 1'b1;
         default: credits_d = credits_q;
      endcase

      pix_cnt_d = pix_cnt_q;
      if (cnt_clr)         pix_cnt_d = '0;
      else if (use_credit) pix_cnt_d = pix_cnt_q + 1'b1;

      data_valid_d = use_credit;
      data_d       = use_credit ? sel_pix.data : data_q;
      data_addr_d  = use_credit ? sel_pix.addr : data_addr_q;
      addr_err_d   = addr_err_q | (xfer & ~addr_ok);
   end

   always_ff @(posedge PPL_clk or negedge rst_n) begin
      if (!rst_n) begin
         credits_q    <= CRED_MAX;
         pix_cnt_q    <= '0;
         last_grant_q <= IDX_W'(N_REQ - 1);
         data_q       <= '0;
         data_addr_q  <= '0;
         data_valid_q <= 1'b0;
         addr_err_q   <= 1'b0;
      end else begin
         credits_q    <= credits_d;
         pix_cnt_q    <= pix_cnt_d;
         last_grant_q <= last_grant_d;
         data_q       <= data_d;
         data_addr_q  <= data_addr_d;
         data_valid_q <= data_valid_d;
         addr_err_q   <= addr_err_d;
      end
   end

   assign data       = data_q;
   assign data_addr  = data_addr_q;
   assign data_valid = data_valid_q;
   assign addr_err   = addr_err_q;

endmodule

// File: tb/tb_ppl_arbiter.sv
// tb_ppl_arbiter: randomized bench with a behavioural reference model.
// A small frame (16x8) keeps full-frame runs short.
module tb_ppl_arbiter;

   localparam int N  = 4;
   localparam int H  = 16;
   localparam int V  = 8;
   localparam int MP = 64;
   localparam int FP = H * V;

   logic            PPL_clk = 1'b0;
   logic            rst_n   = 1'b0;
   logic [N-1:0]    req_valid;
   logic [16*N-1:0] req_data;
   logic [20*N-1:0] req_addr;
   logic [N-1:0]    req_ready;
   logic            frame_start, credit_ret;
   logic [15:0]     data;
   logic [19:0]     data_addr;
   logic            data_valid, frame_done, busy, addr_err;

   always #5 PPL_clk = ~PPL_clk;

   ppl_arbiter #(.N_REQ(N), .H_DISP(H), .V_DISP(V), .MAX_PEND(MP)) dut (
      .PPL_clk     (PPL_clk),
      .rst_n       (rst_n),
      .req_valid   (req_valid),
      .req_data    (req_data),
      .req_addr    (req_addr),
      .req_ready   (req_ready),
      .frame_start (frame_start),
      .credit_ret  (credit_ret),
      .data        (data),
      .data_addr   (data_addr),
      .data_valid  (data_valid),
      .frame_done  (frame_done),
      .busy        (busy),
      .addr_err    (addr_err)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", nm, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   // mode: 0 idle, 1 running, 2 draining
   int          m_mode = 0;
   int          m_cred = MP;
   int          m_pix  = 0;
   int          m_last = N - 1;
   logic        m_dv   = 1'b0;
   logic        m_err  = 1'b0;
   logic [15:0] m_data = '0;
   logic [19:0] m_addr = '0;

   function automatic logic [N-1:0] exp_grant();
      int i;
      if (m_mode != 1 || m_cred == 0) return '0;
      for (int k = 1; k <= N; k++) begin
         i = (m_last + k) % N;
         if (req_valid[i]) return N'(1) << i;
      end
      return '0;
   endfunction

   always @(posedge PPL_clk or negedge rst_n) begin : model
      int          sel;
      logic        ok;
      logic        use_c;
      logic [19:0] a;
      logic [N-1:0] g;
      if (!rst_n) begin
         m_mode <= 0; m_cred <= MP; m_pix <= 0; m_last <= N - 1;
         m_dv <= 1'b0; m_err <= 1'b0; m_data <= '0; m_addr <= '0;
      end else begin
         g   = exp_grant();
         sel = -1;
         for (int i = 0; i < N; i++) if (g[i]) sel = i;
         ok = 1'b1;
         a  = '0;
         if (sel >= 0) begin
            a  = req_addr[20*sel +: 20];
            ok = (int'(a) < FP);
            m_last <= sel;
            if (!ok) m_err <= 1'b1;
         end
         use_c = (sel >= 0) && ok;
         m_dv <= use_c;
         if (use_c) begin
            m_data <= req_data[16*sel +: 16];
            m_addr <= a;
         end
         if (use_c && !credit_ret)                 m_cred <= m_cred - 1;
         else if (credit_ret && !use_c && m_cred < MP) m_cred <= m_cred + 1;
         case (m_mode)
            0: if (frame_start) begin m_pix <= 0; m_mode <= 1; end
            1: if (use_c) begin
                  m_pix <= m_pix + 1;
                  if (m_pix + 1 == FP) m_mode <= 2;
               end
            default: if (m_cred == MP) m_mode <= 0;
         endcase
      end
   end

   // ---------------- compare + monitor ----------------
   int           dv_cnt = 0;
   int           fd_cnt = 0;
   logic         rec    = 1'b0;
   logic [N-1:0] gq[$];

   always @(negedge PPL_clk) begin : cmp
      logic [N-1:0] eg;
      eg = exp_grant();
      chk("req_ready", req_ready, eg);
      chk("data_valid", data_valid, m_dv);
      if (m_dv) begin
         chk("data", data, m_data);
         chk("data_addr", data_addr, m_addr);
      end
      chk("frame_done", frame_done, (m_mode == 2 && m_cred == MP));
      chk("busy", busy, (m_mode != 0));
      chk("addr_err", addr_err, m_err);
      if (data_valid) dv_cnt <= dv_cnt + 1;
      if (frame_done) fd_cnt <= fd_cnt + 1;
      if (rec && req_ready != '0) gq.push_back(req_ready);
   end

   // ---------------- stimulus ----------------
   int   cr_mode    = 0;   // 0 low, 1 loopback, 2 random, 3 always high
   logic rand_valid = 1'b0;
   logic fs_rand    = 1'b0;
   logic bad_addr1  = 1'b0;

   task automatic step();
      @(posedge PPL_clk);
      #1;
   endtask

   task automatic cyc();
      step();
      frame_start = 1'b0;
      case (cr_mode)
         0:       credit_ret = 1'b0;
         1:       credit_ret = data_valid;
         2:       credit_ret = 1'($urandom_range(0, 1));
         default: credit_ret = 1'b1;
      endcase
      if (rand_valid) req_valid = N'($urandom);
      for (int i = 0; i < N; i++) begin
         req_data[16*i +: 16] = 16'($urandom);
         req_addr[20*i +: 20] = 20'($urandom_range(0, FP - 1));
      end
      if (bad_addr1) req_addr[20 +: 20] = 20'(FP);
      if (fs_rand && $urandom_range(0, 15) == 0) frame_start = 1'b1;
   endtask

   task automatic wait_done(input string nm, input int lim);
      int f0;
      int n;
      f0 = fd_cnt;
      n  = 0;
      while (fd_cnt == f0 && n < lim) begin
         cyc();
         n++;
      end
      frame_start = 1'b0;
      chk(nm, (fd_cnt != f0), 1);
   endtask

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin : drive
      int snap, snap2, f0;
      req_valid = '0; req_data = '0; req_addr = '0;
      frame_start = 1'b0; credit_ret = 1'b0;
      repeat (3) step();
      chk("rst_ready", req_ready, 0);
      chk("rst_data", {data_addr, data}, 0);
      chk("rst_dvalid", data_valid, 0);
      chk("rst_done", frame_done, 0);
      chk("rst_busy", busy, 0);
      chk("rst_err", addr_err, 0);
      rst_n = 1'b1;
      step();

      // full frame, all requesters valid, credits looped back
      cr_mode = 1; req_valid = '1; rec = 1'b1;
      snap = dv_cnt; f0 = fd_cnt;
      frame_start = 1'b1;
      cyc();
      wait_done("p1_done", 2000);
      rec = 1'b0;
      chk("p1_pixels", dv_cnt - snap, FP);
      chk("p1_fdone", fd_cnt - f0, 1);
      chk("p1_gq_len", (gq.size() >= 8), 1);
      for (int k = 0; k < 8 && k < gq.size(); k++)
         chk($sformatf("p1_grant%0d", k), gq[k], 1 << (k % 4));
      cyc();
      chk("p1_busy", busy, 0);

      // no credit return: pool drains after MP transfers
      cr_mode = 0; req_valid = 4'b0100;
      snap = dv_cnt;
      frame_start = 1'b1;
      cyc();
      repeat (100) cyc();
      chk("p2_xfers", dv_cnt - snap, MP);
      chk("p2_blocked", req_ready, 0);
      snap2 = dv_cnt;
      credit_ret = 1'b1;
      repeat (10) cyc();
      chk("p2_one_more", dv_cnt - snap2, 1);

      // transfer + return every cycle at one credit
      cr_mode = 3;
      repeat (3) cyc();
      snap2 = dv_cnt;
      repeat (20) cyc();
      chk("p3_thru", dv_cnt - snap2, 20);

      // out-of-range address from requester 1
      cr_mode = 0; req_valid = 4'b0010; bad_addr1 = 1'b1;
      cyc();
      bad_addr1 = 1'b0;
      cyc();
      #1;
      chk("p4_err", addr_err, 1);
      chk("p4_nodv", data_valid, 0);
      chk("p4_credit_kept", req_ready, 4'b0010);

      // finish the frame with random traffic and stray frame_start pulses
      cr_mode = 2; rand_valid = 1'b1; fs_rand = 1'b1;
      wait_done("p4_done", 4000);
      fs_rand = 1'b0; rand_valid = 1'b0;
      chk("p4_pixels", dv_cnt - snap, FP);

      // reset in the middle of a frame
      req_valid = '1; cr_mode = 2;
      frame_start = 1'b1;
      cyc();
      repeat (70) cyc();
      f0 = fd_cnt;
      rst_n = 1'b0;
      repeat (2) cyc();
      chk("p5_rst_busy", busy, 0);
      chk("p5_rst_dv", data_valid, 0);
      chk("p5_rst_ready", req_ready, 0);
      rst_n = 1'b1;
      cyc();
      chk("p5_no_done", fd_cnt - f0, 0);
      gq.delete();
      rec = 1'b1;
      snap = dv_cnt;
      frame_start = 1'b1;
      cyc();
      wait_done("p5_done", 4000);
      rec = 1'b0;
      chk("p5_first", (gq.size() > 0) ? gq[0] : '0, 1);
      chk("p5_pixels", dv_cnt - snap, FP);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ppl_arbiter.md
# ppl_arbiter

Round-robin arbiter and frame sequencer that shares the single pixel-alignment path (sort + line FIFO + video-clock readout) among N_REQ parallel render pipelines. Each pipeline presents pixels tagged with a linear frame address. The arbiter serialises them into one `data`/`data_addr`/`data_valid` stream in the PPL_clk domain. It throttles with a credit counter so the downstream line FIFO never overflows, and it brackets each frame between a `frame_start` pulse and a `frame_done` pulse.

## Interface
Parameters:
- N_REQ, 4, number of render pipelines (requesters), 2..8
- H_DISP, 1280, active pixels per line
- V_DISP, 720, active lines per frame
- MAX_PEND, 64, pixels allowed in flight downstream; this is the credit pool size

Ports:
- PPL_clk  in  1  pipeline clock; the only clock
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  N_REQ  requester i holds a pixel
- req_data  in  16*N_REQ  RGB565 pixel, requester i at bits [16i+15:16i]
- req_addr  in  20*N_REQ  linear address (line*H_DISP + column), requester i at bits [20i+19:20i]
- req_ready  out  N_REQ  one-hot grant; transfer occurs when req_valid[i] & req_ready[i]
- frame_start  in  1  single-cycle pulse, already synchronised to PPL_clk
- credit_ret  in  1  single-cycle pulse; one downstream pixel consumed
- data  out  16  granted pixel
- data_addr  out  20  granted address
- data_valid  out  1  data/data_addr valid, one cycle per pixel
- frame_done  out  1  single-cycle pulse at end of frame
- busy  out  1  high while state is not IDLE
- addr_err  out  1  sticky; an out-of-range address was dropped

## Operation
- States:
  - IDLE: no grants. On frame_start, clear the pixel counter and go to RUN.
  - RUN: arbitrate every cycle. When the accepted-pixel count reaches H_DISP*V_DISP, go to DRAIN.
  - DRAIN: no grants. When credits == MAX_PEND, pulse frame_done and go to IDLE.
- frame_start is ignored in RUN and DRAIN.
- Grant rule: a requester is eligible when state==RUN, credits>0 and req_valid[i]==1.
  - Priority starts at last_grant+1 and wraps modulo N_REQ.
  - At most one grant per cycle.
  - req_ready is combinational from req_valid, state and credits; requesters must not make req_valid depend on req_ready.
- last_grant updates only on an accepted transfer.
- Credits: counter of width clog2(MAX_PEND)+1, reset to MAX_PEND.
  - Transfer only: decrement. credit_ret only: increment. Both in the same cycle: unchanged.
  - Increment saturates at MAX_PEND; excess credit_ret is ignored.
- Address check: if req_addr >= H_DISP*V_DISP, the transfer is still accepted, consumes no credit and is not counted. data_valid stays low for it and addr_err sets. addr_err clears only on reset.
- Pixel counter: width clog2(H_DISP*V_DISP)+1 (21 bits at the defaults); counts valid accepted pixels only.

## Timing
- Grant to data_valid latency: 1 cycle. data, data_addr and data_valid are registered.
- Throughput: 1 pixel per cycle while credits>0.
- Transfers that would need credit are blocked in the same cycle the credit count reaches 0.
- frame_start registered in IDLE puts the FSM in RUN next cycle; the first grant can occur that cycle.
- The last pixel is accepted in cycle t; state is DRAIN at t+1.
- frame_done is high for exactly the cycle in which state goes DRAIN→IDLE. busy is low from the following cycle.
- Reset values of all outputs:
  - req_ready=0, data=0, data_addr=0, data_valid=0
  - frame_done=0, busy=0, addr_err=0
- Reset internal state: credits=MAX_PEND, last_grant=N_REQ-1 (requester 0 has first priority), state=IDLE.
- Reset asserted mid-frame discards all state immediately; no frame_done is produced.

## Structure
- Shared package `ppl_pkg`:
  - state encoding (IDLE, RUN, DRAIN)
  - PIX_W=16, ADDR_W=20
  - FRAME_PIX = H_DISP*V_DISP
- Sub-module `rr_arbiter`: parameterised N-way round-robin, with ports req[N], en, advance, grant[N] and last pointer. Everything else is flat in `ppl_arbiter`.

## Test plan
- Reset, then frame_start with all 4 requesters valid continuously and credit_ret looped back after 1 cycle:
  - grants cycle 0,1,2,3,0,…
  - exactly 921600 data_valid pulses
  - one frame_done, then busy=0
- credit_ret tied low, MAX_PEND=64, requester 2 always valid:
  - exactly 64 transfers, then req_ready stays 0
  - a single credit_ret pulse releases exactly one more transfer
- Simultaneous transfer and credit_ret every cycle at credits=1: credits stay at 1 and throughput stays at 1 pixel/cycle.
- Requester 1 sends addr=921600:
  - the transfer is accepted with no data_valid
  - addr_err=1, credits unchanged
  - the frame still needs 921600 valid pixels to complete
- frame_start pulsed during RUN and during DRAIN: no state change and the pixel count is not reset.
- rst_n asserted at pixel 500000 and released, then frame_start: the full frame completes from count 0 and requester 0 is granted first.
